// File: rtl/kmac_right_decode_if.sv
// Byte-stream input and decoded-result output bundle for kmac_right_decode.
// The decoder takes the slave view; the byte source / result consumer takes the master view.
interface kmac_right_decode_if #(
    parameter int MAX_BYTES = 8
);
    logic                   s_valid;
    logic                   s_ready;
    logic [7:0]             s_data;
    logic                   s_last;
    logic                   m_valid;
    logic                   m_ready;
    logic [8*MAX_BYTES-1:0] m_value;
    logic [7:0]             m_nbytes;
    logic                   m_error;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_value, m_nbytes, m_error
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_value, m_nbytes, m_error
    );
endinterface

// File: rtl/kmac_right_decode.sv
// Streaming decoder for the SP 800-185 right_encode(x) format: O_1..O_n || n -> x.
// Define RD_CANON_CHECK_EN to reject non-minimal encodings (leading zero byte when n>1).
module kmac_right_decode #(
    parameter int MAX_BYTES = 8
) (
    input logic             clk,
    input logic             rst_n,
    kmac_right_decode_if.slave bus
);
    localparam int W = 8 * MAX_BYTES;
    localparam logic [7:0] MAX_N = 8'(MAX_BYTES);

    typedef enum logic {COLLECT, RESULT} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   acc;
    logic [7:0]     cnt;
    logic           ovf;
    logic           err;
    logic           take;

`ifdef RD_CANON_CHECK_EN
    logic           first_zero;
`endif

    assign take = bus.s_valid & (state == COLLECT);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_nxt;
    end

    // NOTE: default assignment first, so no path leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (take && bus.s_last) state_nxt = RESULT;
            RESULT:  if (bus.m_ready)        state_nxt = COLLECT;
            default:                         state_nxt = COLLECT;
        endcase
    end

    // Handshake strobes decode the registered state only.
    always_comb begin
        bus.s_ready = 1'b0;
        bus.m_valid = 1'b0;
        case (state)
            COLLECT: bus.s_ready = 1'b1;
            RESULT:  bus.m_valid = 1'b1;
            default: bus.s_ready = 1'b1;
        endcase
    end

    always_comb begin
        err = (bus.s_data == 8'd0) | (bus.s_data > MAX_N) | ovf | (bus.s_data != cnt);
`ifdef RD_CANON_CHECK_EN
        err = err | ((cnt > 8'd1) & first_zero);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            cnt          <= '0;
            ovf          <= 1'b0;
            bus.m_value  <= '0;
            bus.m_nbytes <= '0;
            bus.m_error  <= 1'b0;
`ifdef RD_CANON_CHECK_EN
            first_zero   <= 1'b0;
`endif
        end else if (take && !bus.s_last) begin
            // Shift form stays legal for MAX_BYTES=1, where a part-select would go negative.
            acc <= (acc << 8) | W'(bus.s_data);
            if (cnt != 8'd255) cnt <= cnt + 8'd1;
            if (cnt >= MAX_N)  ovf <= 1'b1;
`ifdef RD_CANON_CHECK_EN
            if (cnt == 8'd0)   first_zero <= (bus.s_data == 8'd0);
`endif
        end else if (take && bus.s_last) begin
            bus.m_nbytes <= bus.s_data;
            bus.m_value  <= err ? '0 : acc;
            bus.m_error  <= err;
        end else if (state == RESULT && bus.m_ready) begin
            acc        <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
`ifdef RD_CANON_CHECK_EN
            first_zero <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_kmac_right_decode.sv
// Directed, table-driven bench for kmac_right_decode (MAX_BYTES=8) plus multi-cycle corner sequences.
module tb_kmac_right_decode;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    kmac_right_decode_if #(.MAX_BYTES(8)) bus ();
    kmac_right_decode #(.MAX_BYTES(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int               nv;
        logic [0:9][7:0]  b;
        logic [7:0]       len;
        logic [63:0]      val;
        logic             err;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, output int stalls);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        stalls = 0;
        while (!bus.s_ready && stalls < 20) begin
            @(posedge clk); #1;
            stalls++;
        end
        if (!bus.s_ready) check("s_ready_timeout", 64'(bus.s_ready), 64'd1);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_frame(input vec_t v);
        int st;
        for (int i = 0; i < v.nv; i++) send_byte(v.b[i], 1'b0, st);
        send_byte(v.len, 1'b1, st);
    endtask

    task automatic check_result(input string tag, input logic [63:0] val, input logic [7:0] nb,
                                input logic e);
        check({tag, "_m_valid"},  64'(bus.m_valid),  64'd1);
        check({tag, "_s_ready"},  64'(bus.s_ready),  64'd0);
        check({tag, "_m_value"},  bus.m_value,       val);
        check({tag, "_m_nbytes"}, 64'(bus.m_nbytes), 64'(nb));
        check({tag, "_m_error"},  64'(bus.m_error),  64'(e));
    endtask

    initial begin
        int st;

        vecs[0] = '{1, 80'h00_000000000000000000, 8'h01, 64'h0, 1'b0};
        vecs[1] = '{3, 80'h123456_00000000000000, 8'h03, 64'h123456, 1'b0};
        vecs[2] = '{2, 80'h1234_0000000000000000, 8'h03, 64'h0, 1'b1};
        vecs[3] = '{0, 80'h0, 8'h00, 64'h0, 1'b1};
        vecs[4] = '{9, 80'h010203040506070809_00, 8'h09, 64'h0, 1'b1};
`ifdef RD_CANON_CHECK_EN
        vecs[5] = '{2, 80'h0005_0000000000000000, 8'h02, 64'h0, 1'b1};
`else
        vecs[5] = '{2, 80'h0005_0000000000000000, 8'h02, 64'h5, 1'b0};
`endif
        vecs[6] = '{0, 80'h0, 8'h01, 64'h0, 1'b1};
        vecs[7] = '{8, 80'h0102030405060708_0000, 8'h08, 64'h0102030405060708, 1'b0};
        vecs[8] = '{1, 80'hFF_000000000000000000, 8'h01, 64'hFF, 1'b0};
        vecs[9] = '{2, 80'hAABB_0000000000000000, 8'h02, 64'hAABB, 1'b0};

        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;
        #12;
        check("rst_m_valid",  64'(bus.m_valid),  64'd0);
        check("rst_m_value",  bus.m_value,       64'd0);
        check("rst_m_nbytes", 64'(bus.m_nbytes), 64'd0);
        check("rst_m_error",  64'(bus.m_error),  64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_s_ready", 64'(bus.s_ready), 64'd1);

        for (int i = 0; i < 10; i++) begin
            send_frame(vecs[i]);
            check_result($sformatf("vec%0d", i), vecs[i].val, vecs[i].len, vecs[i].err);
            @(posedge clk); #1;
            check($sformatf("vec%0d_back_m_valid", i), 64'(bus.m_valid), 64'd0);
            check($sformatf("vec%0d_back_s_ready", i), 64'(bus.s_ready), 64'd1);
        end

        // Back-to-back frames: next frame's first byte stalls exactly one cycle.
        send_frame(vecs[1]);
        check_result("b2b_a", 64'h123456, 8'h03, 1'b0);
        send_byte(8'h7E, 1'b0, st);
        check("b2b_stall_cycles", 64'(st), 64'd1);
        send_byte(8'h01, 1'b1, st);
        check("b2b_stall_none", 64'(st), 64'd0);
        check_result("b2b_b", 64'h7E, 8'h01, 1'b0);
        @(posedge clk); #1;

        // Backpressure: result held, stray input ignored, outputs stable.
        bus.m_ready = 1'b0;
        send_frame(vecs[9]);
        check_result("bp_enter", 64'hAABB, 8'h02, 1'b0);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h77;
        bus.s_last  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_result($sformatf("bp_hold%0d", c), 64'hAABB, 8'h02, 1'b0);
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_rel_m_valid", 64'(bus.m_valid), 64'd0);
        check("bp_rel_s_ready", 64'(bus.s_ready), 64'd1);
        check("bp_rel_m_value", bus.m_value, 64'hAABB);

        // Reset mid-frame discards partial bytes.
        send_byte(8'h12, 1'b0, st);
        send_byte(8'h34, 1'b0, st);
        rst_n = 1'b0;
        #2;
        check("midrst_m_value", bus.m_value, 64'd0);
        check("midrst_m_nbytes", 64'(bus.m_nbytes), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_byte(8'hAB, 1'b0, st);
        send_byte(8'h01, 1'b1, st);
        check_result("midrst", 64'hAB, 8'h01, 1'b0);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
